// File: rtl/register_file.sv
// register_file: 32 x 32-bit MIPS GPR file with a destination busy scoreboard.
// Two combinational read ports, one write-back port, one issue (reserve) port.
// r0 is hard-wired to zero and never marked busy.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write-back
// data to the read ports and mask the written register's busy bit from stall.

module regfile_entry #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set,
  input  logic              clr,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  // Register contents plus pending bit; a new reservation outranks a
  // write-back landing on the same edge since the newer producer owns it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
      busy <= 1'b0;
    end else begin
      if (wr_en) data <= wr_data;
      if (set)      busy <= 1'b1;
      else if (clr) busy <= 1'b0;
    end
  end

endmodule

module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_W-1:0]      read_reg1,
  input  logic [ADDR_W-1:0]      read_reg2,
  output logic [DATA_W-1:0]      read_data1,
  output logic [DATA_W-1:0]      read_data2,
  input  logic [ADDR_W-1:0]      write_reg,
  input  logic [DATA_W-1:0]      write_data,
  input  logic                   reg_write,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_reg,
  output logic                   stall,
  output logic [(1<<ADDR_W)-1:0] busy_vec
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy;
  logic                            wr_act;
  logic                            iss_act;
  logic                            byp1;
  logic                            byp2;

  // Writes and issues to r0 are dropped here so no entry ever sees them.
  assign wr_act  = reg_write   && (write_reg != '0);
  assign iss_act = issue_valid && (issue_reg != '0);

  assign regs[0] = '0;
  assign busy[0] = 1'b0;

  genvar n;
  generate
    for (n = 1; n < NUM_REGS; n++) begin : g_entry
      regfile_entry #(.DATA_W(DATA_W)) u_entry (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_act && (write_reg == ADDR_W'(n))),
        .wr_data (write_data),
        .set     (iss_act && (issue_reg == ADDR_W'(n))),
        .clr     (wr_act && (write_reg == ADDR_W'(n))),
        .data    (regs[n]),
        .busy    (busy[n])
      );
    end
  endgenerate

  // Read ports; optional same-cycle forward of write-back data, forced to
  // zero while reset is held so an in-flight write cannot leak out.
  always_comb begin
    read_data1 = regs[read_reg1];
    read_data2 = regs[read_reg2];
    byp1       = 1'b0;
    byp2       = 1'b0;
`ifdef REGFILE_BYPASS_EN
    byp1 = wr_act && (write_reg == read_reg1);
    byp2 = wr_act && (write_reg == read_reg2);
    if (byp1) read_data1 = write_data;
    if (byp2) read_data2 = write_data;
`endif
    if (!reset_n) begin
      read_data1 = '0;
      read_data2 = '0;
    end
  end

  // Stall on any busy nonzero source not being satisfied by a forward this cycle.
  always_comb begin
    stall = reset_n &&
            ((busy[read_reg1] && !byp1) || (busy[read_reg2] && !byp2));
  end

  assign busy_vec = busy;

endmodule
